// File: rtl/dbgu_burst_engine_pkg.sv
// Shared opcodes, NAK byte, FSM state encoding and mode register layout
// for the debug burst engine.
`default_nettype none

package dbgu_burst_engine_pkg;

    localparam logic [7:0] OP_SETADR  = 8'h01;
    localparam logic [7:0] OP_HALT    = 8'h02;
    localparam logic [7:0] OP_RUN     = 8'h03;
    localparam logic [7:0] OP_WRITE   = 8'h04;
    localparam logic [7:0] OP_READ    = 8'h05;
    localparam logic [7:0] OP_SETCNT  = 8'h06;
    localparam logic [7:0] OP_BWRITE  = 8'h07;
    localparam logic [7:0] OP_BREAD   = 8'h08;
    localparam logic [7:0] OP_SETMODE = 8'h09;
    localparam logic [7:0] NAK_BYTE   = 8'h15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_MEM  = 2'd2,
        ST_TX   = 2'd3
    } state_t;

    typedef struct packed {
        logic autoinc;
    } mode_t;

    function automatic logic is_read_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_BREAD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dbgu_byte_shifter.sv
// Little-endian byte assembly / disassembly register with a byte counter;
// shared by argument collection and transmit serialisation.
`default_nettype none

module dbgu_byte_shifter #(
    parameter int BYTES = 4,
    localparam int CW = $clog2(BYTES + 1)
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 clear,
    input  logic                 load,
    input  logic [8*BYTES-1:0]   load_data,
    input  logic                 shift_in,
    input  logic [7:0]           byte_in,
    input  logic                 shift_out,
    output logic [8*BYTES-1:0]   merged,
    output logic [7:0]           next_out,
    output logic [CW-1:0]        count
);

    logic [8*BYTES-1:0] data;
    logic [8*BYTES-1:0] shr;

    // merged is the word as it will look once byte_in lands at the current slot
    always_comb begin
        merged = data;
        for (int i = 0; i < BYTES; i++) begin
            if (count == CW'(i)) merged[i*8 +: 8] = byte_in;
        end
        shr      = data >> 8;
        next_out = shr[7:0];
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            data  <= '0;
            count <= '0;
        end else if (clear) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= '0;
        end else if (shift_in) begin
            data  <= merged;
            count <= count + CW'(1);
        end else if (shift_out) begin
            data  <= shr;
            count <= count + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dbgu_burst_engine.sv
// Debug command engine: decodes a UART byte stream into pointer set-up,
// single/burst memory accesses and CPU reset control.
`default_nettype none

module dbgu_burst_engine
    import dbgu_burst_engine_pkg::*;
#(
    parameter int   ADDR_W     = 32,
    parameter int   DATA_BYTES = 4,
    parameter int   TIMEOUT    = 100000,
    parameter logic RUN_AT_RST = 1'b1
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    mem_op,
    output logic [ADDR_W-1:0]       mem_adr,
    output logic [8*DATA_BYTES-1:0] mem_do,
    output logic [DATA_BYTES-1:0]   mem_wren,
    input  logic [8*DATA_BYTES-1:0] mem_di,
    input  logic                    mem_ack,
    output logic                    cpu_n_reset,
    output logic                    busy
);

    localparam int AB = ADDR_W / 8;
    localparam int SB = (AB > DATA_BYTES) ? AB : DATA_BYTES;
    localparam int SW = 8 * SB;
    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = $clog2(SB + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [7:0]          op;
    logic [CW-1:0]       need;
    logic [ADDR_W-1:0]   ptr;
    logic [7:0]          cnt;
    logic [7:0]          left;
    mode_t               mode;
    logic [TW-1:0]       tmo;
    logic                nak;

    logic                sh_clear, sh_load, sh_in, sh_out, last;
    logic [SW-1:0]       merged;
    logic [7:0]          next_out;
    logic [CW-1:0]       count;

    assign last     = (count == CW'(DATA_BYTES - 1));
    assign sh_clear = (state == ST_IDLE && rx_valid) ||
                      (state == ST_MEM && mem_ack && !is_read_op(op));
    assign sh_load  = (state == ST_MEM) && mem_ack && is_read_op(op);
    assign sh_in    = (state == ST_ARG) && rx_valid;
    assign sh_out   = (state == ST_TX) && tx_ready && !nak && !last;
    assign busy     = (state != ST_IDLE);

    dbgu_byte_shifter #(.BYTES(SB)) u_shifter (
        .clk       (clk),
        .n_reset   (n_reset),
        .clear     (sh_clear),
        .load      (sh_load),
        .load_data (SW'(mem_di)),
        .shift_in  (sh_in),
        .byte_in   (rx_data),
        .shift_out (sh_out),
        .merged    (merged),
        .next_out  (next_out),
        .count     (count)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= ST_IDLE;
            op           <= '0;
            need         <= '0;
            ptr          <= '0;
            cnt          <= '0;
            left         <= '0;
            mode.autoinc <= 1'b1;
            tmo          <= '0;
            nak          <= 1'b0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            mem_op       <= 1'b0;
            mem_adr      <= '0;
            mem_do       <= '0;
            mem_wren     <= '0;
            cpu_n_reset  <= RUN_AT_RST;
        end else begin
            // Silence timer only runs while waiting for argument bytes
            if (rx_valid || state != ST_ARG) tmo <= '0;
            else                             tmo <= tmo + TW'(1);

            case (state)
                ST_IDLE: if (rx_valid) begin
                    op <= rx_data;
                    case (rx_data)
                        OP_SETADR: begin need <= CW'(AB); state <= ST_ARG; end
                        OP_HALT:   cpu_n_reset <= 1'b0;
                        OP_RUN:    cpu_n_reset <= 1'b1;
                        OP_WRITE: begin
                            need <= CW'(DATA_BYTES); left <= '0; state <= ST_ARG;
                        end
                        OP_SETCNT, OP_SETMODE: begin need <= CW'(1); state <= ST_ARG; end
                        OP_BWRITE: begin
                            need <= CW'(DATA_BYTES); left <= cnt; state <= ST_ARG;
                        end
                        OP_READ, OP_BREAD: begin
                            left     <= (rx_data == OP_BREAD) ? cnt : 8'd0;
                            mem_op   <= 1'b1;
                            mem_adr  <= ptr;
                            mem_wren <= '0;
                            state    <= ST_MEM;
                        end
                        default: begin
                            nak      <= 1'b1;
                            tx_data  <= NAK_BYTE;
                            tx_valid <= 1'b1;
                            state    <= ST_TX;
                        end
                    endcase
                end
                ST_ARG: begin
                    if (rx_valid) begin
                        if (count == need - CW'(1)) begin
                            case (op)
                                OP_SETADR:  begin ptr <= merged[ADDR_W-1:0]; state <= ST_IDLE; end
                                OP_SETCNT:  begin cnt <= merged[7:0];        state <= ST_IDLE; end
                                OP_SETMODE: begin mode.autoinc <= merged[0]; state <= ST_IDLE; end
                                default: begin
                                    mem_op   <= 1'b1;
                                    mem_adr  <= ptr;
                                    mem_do   <= merged[DW-1:0];
                                    mem_wren <= '1;
                                    state    <= ST_MEM;
                                end
                            endcase
                        end
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_MEM: if (mem_ack) begin
                    mem_op   <= 1'b0;
                    mem_wren <= '0;
                    if (mode.autoinc) ptr <= ptr + ADDR_W'(DATA_BYTES);
                    if (is_read_op(op)) begin
                        tx_data  <= mem_di[7:0];
                        tx_valid <= 1'b1;
                        state    <= ST_TX;
                    end else if (left == 8'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        left  <= left - 8'd1;
                        state <= ST_ARG;
                    end
                end
                ST_TX: if (tx_ready) begin
                    if (nak) begin
                        nak      <= 1'b0;
                        tx_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (last) begin
                        tx_valid <= 1'b0;
                        if (left == 8'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            left    <= left - 8'd1;
                            mem_op  <= 1'b1;
                            mem_adr <= ptr;
                            state   <= ST_MEM;
                        end
                    end else begin
                        tx_data <= next_out;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dbgu_burst_engine.sv
// Self-checking bench: directed scenarios plus randomized command mix
// against a command-level reference model of the debug engine.
`default_nettype none

module tb_dbgu_burst_engine;

    localparam int TMO   = 200;
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_op;
    logic [31:0] mem_adr;
    logic [31:0] mem_do;
    logic [3:0]  mem_wren;
    logic [31:0] mem_di;
    logic        mem_ack;
    logic        cpu_n_reset;
    logic        busy;

    always #5 clk = ~clk;

    dbgu_burst_engine #(.ADDR_W(32), .DATA_BYTES(4), .TIMEOUT(TMO), .RUN_AT_RST(1'b1)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .mem_op      (mem_op),
        .mem_adr     (mem_adr),
        .mem_do      (mem_do),
        .mem_wren    (mem_wren),
        .mem_di      (mem_di),
        .mem_ack     (mem_ack),
        .cpu_n_reset (cpu_n_reset),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] m_ptr;
    logic [7:0]  m_cnt;
    bit          m_auto;
    logic [31:0] m_mem [logic [31:0]];
    logic [31:0] e_adr[$], e_do[$];
    logic [3:0]  e_wren[$];
    logic [7:0]  e_tx[$];

    // ---------------- observed side ----------------
    logic [31:0] s_mem [logic [31:0]];
    logic [31:0] o_adr[$], o_do[$];
    logic [3:0]  o_wren[$];
    logic [7:0]  o_tx[$];
    bit          stall = 1'b0;
    bit          hold_ack = 1'b0;
    int          fixed_dly = -1;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] + 16'h1234};
    endfunction

    function automatic int pick_dly();
        return (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 4));
    endfunction

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Memory slave: acks after a delay, logs every completed access
    initial begin
        int dly;
        mem_ack = 1'b0;
        mem_di  = '0;
        dly     = 0;
        forever begin
            @(negedge clk);
            if (!n_reset || hold_ack) begin
                mem_ack = 1'b0;
                dly     = pick_dly();
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                mem_di  = '0;
                dly     = pick_dly();
            end else if (mem_op) begin
                if (dly == 0) begin
                    mem_ack = 1'b1;
                    o_adr.push_back(mem_adr);
                    o_do.push_back(mem_do);
                    o_wren.push_back(mem_wren);
                    if (mem_wren != 4'h0) s_mem[mem_adr] = mem_do;
                    else mem_di = s_mem.exists(mem_adr) ? s_mem[mem_adr] : mem_init(mem_adr);
                end else begin
                    dly--;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (n_reset && tx_valid && tx_ready) o_tx.push_back(tx_data);
    end

    // ---------------- model actions ----------------
    task automatic model_access(input bit wr, input logic [31:0] d);
        logic [31:0] v;
        e_adr.push_back(m_ptr);
        e_do.push_back(d);
        e_wren.push_back(wr ? 4'hF : 4'h0);
        if (wr) begin
            m_mem[m_ptr] = d;
        end else begin
            v = m_mem.exists(m_ptr) ? m_mem[m_ptr] : mem_init(m_ptr);
            for (int i = 0; i < 4; i++) e_tx.push_back(v[8*i +: 8]);
        end
        if (m_auto) m_ptr = m_ptr + 32'd4;
    endtask

    task automatic wait_mem_idle();
        int t = 0;
        while (mem_op && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) check_value("mem_ack_timeout", {63'd0, mem_op}, 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        wait_mem_idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic drain(input string tag);
        check_value({tag, "_nmem"}, 64'(o_adr.size()), 64'(e_adr.size()));
        while (o_adr.size() > 0 && e_adr.size() > 0) begin
            logic [31:0] oa, od, ea, ed;
            logic [3:0]  ow, ew;
            oa = o_adr.pop_front(); od = o_do.pop_front(); ow = o_wren.pop_front();
            ea = e_adr.pop_front(); ed = e_do.pop_front(); ew = e_wren.pop_front();
            check_value({tag, "_adr"}, 64'(oa), 64'(ea));
            check_value({tag, "_wren"}, 64'(ow), 64'(ew));
            if (ew != 4'h0) check_value({tag, "_do"}, 64'(od), 64'(ed));
        end
        check_value({tag, "_ntx"}, 64'(o_tx.size()), 64'(e_tx.size()));
        while (o_tx.size() > 0 && e_tx.size() > 0)
            check_value({tag, "_tx"}, 64'(o_tx.pop_front()), 64'(e_tx.pop_front()));
        o_adr.delete(); o_do.delete(); o_wren.delete(); o_tx.delete();
        e_adr.delete(); e_do.delete(); e_wren.delete(); e_tx.delete();
    endtask

    task automatic finish_cmd(input string tag);
        int t = 0;
        while (busy && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check_value({tag, "_idle"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        drain(tag);
    endtask

    task automatic cmd_setadr(input logic [31:0] a);
        send_byte(8'h01); send_word(a); m_ptr = a; finish_cmd("setadr");
    endtask
    task automatic cmd_write(input logic [31:0] d);
        send_byte(8'h04); send_word(d); model_access(1'b1, d); finish_cmd("write");
    endtask
    task automatic cmd_read();
        send_byte(8'h05); model_access(1'b0, 32'd0); finish_cmd("read");
    endtask
    task automatic cmd_setcnt(input logic [7:0] n);
        send_byte(8'h06); send_byte(n); m_cnt = n; finish_cmd("setcnt");
    endtask
    task automatic cmd_bwrite();
        logic [31:0] d;
        send_byte(8'h07);
        for (int i = 0; i <= int'(m_cnt); i++) begin
            d = $urandom;
            send_word(d);
            model_access(1'b1, d);
        end
        finish_cmd("bwrite");
    endtask
    task automatic cmd_bread();
        send_byte(8'h08);
        for (int i = 0; i <= int'(m_cnt); i++) model_access(1'b0, 32'd0);
        finish_cmd("bread");
    endtask
    task automatic cmd_setmode(input logic [7:0] b);
        send_byte(8'h09); send_byte(b); m_auto = b[0]; finish_cmd("setmode");
    endtask
    task automatic cmd_ctrl(input bit run);
        send_byte(run ? 8'h03 : 8'h02);
        check_value(run ? "run_cpu" : "halt_cpu", {63'd0, cpu_n_reset}, {63'd0, run});
        finish_cmd("ctrl");
    endtask
    task automatic cmd_bad(input logic [7:0] op);
        send_byte(op); e_tx.push_back(8'h15); finish_cmd("nak");
    endtask

    task automatic model_reset();
        m_ptr = '0; m_cnt = '0; m_auto = 1'b1;
    endtask

    initial begin
        logic [7:0] bad;
        n_reset  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_value("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check_value("rst_tx_data", 64'(tx_data), 64'd0);
        check_value("rst_mem_op", {63'd0, mem_op}, 64'd0);
        check_value("rst_mem_adr", 64'(mem_adr), 64'd0);
        check_value("rst_mem_do", 64'(mem_do), 64'd0);
        check_value("rst_mem_wren", 64'(mem_wren), 64'd0);
        check_value("rst_cpu", {63'd0, cpu_n_reset}, 64'd1);
        check_value("rst_busy", {63'd0, busy}, 64'd0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // single write then read-back of the auto-incremented pointer
        cmd_setadr(32'h20);
        cmd_write(32'hAABBCCDD);
        cmd_read();

        // read with the UART stalled
        cmd_setadr(32'h20);
        stall = 1'b1;
        send_byte(8'h05);
        model_access(1'b0, 32'd0);
        repeat (50) @(negedge clk);
        check_value("stall_valid", {63'd0, tx_valid}, 64'd1);
        check_value("stall_byte", 64'(tx_data), 64'(e_tx[0]));
        check_value("stall_nobytes", 64'(o_tx.size()), 64'd0);
        stall = 1'b0;
        finish_cmd("stall_read");

        // burst write with slow acks
        fixed_dly = 5;
        cmd_setcnt(8'd2);
        cmd_setadr(32'h100);
        cmd_bwrite();
        fixed_dly = -1;
        cmd_bread();

        // timeout mid-argument leaves the pointer alone
        send_byte(8'h01);
        send_byte(8'h20);
        repeat (TMO + 20) @(negedge clk);
        check_value("tmo_busy", {63'd0, busy}, 64'd0);
        cmd_read();

        // pointer wrap
        cmd_setadr(32'hFFFF_FFFC);
        cmd_write(32'h1234_5678);
        cmd_read();

        // control opcodes and non-incrementing mode
        cmd_bad(8'h7F);
        cmd_ctrl(1'b0);
        cmd_ctrl(1'b1);
        cmd_setmode(8'h00);
        cmd_read();
        cmd_read();
        cmd_setmode(8'h01);

        // randomized command mix
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0: cmd_setadr(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC));
                1: cmd_write($urandom);
                2: cmd_read();
                3: cmd_setcnt(8'($urandom_range(0, 3)));
                4: cmd_bwrite();
                5: cmd_bread();
                6: cmd_setmode(8'($urandom));
                7: cmd_ctrl(1'($urandom));
                8: begin
                    bad = 8'($urandom_range(10, 255));
                    if ($urandom_range(0, 4) == 0) bad = 8'h00;
                    cmd_bad(bad);
                end
                default: cmd_read();
            endcase
        end

        // asynchronous reset in the middle of a burst read
        cmd_setmode(8'h01);
        cmd_setcnt(8'd3);
        cmd_setadr(32'h40);
        hold_ack = 1'b1;
        @(negedge clk);
        rx_data  = 8'h08;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_value("pre_rst_op", {63'd0, mem_op}, 64'd1);
        #2 n_reset = 1'b0;
        #1;
        check_value("arst_mem_op", {63'd0, mem_op}, 64'd0);
        check_value("arst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check_value("arst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        n_reset  = 1'b1;
        hold_ack = 1'b0;
        model_reset();
        o_adr.delete(); o_do.delete(); o_wren.delete(); o_tx.delete();
        e_adr.delete(); e_do.delete(); e_wren.delete(); e_tx.delete();
        @(negedge clk);
        cmd_bread();
        cmd_read();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
